// File: rtl/inv_pi_engine_if.sv
// Handshake bundle between the permutation core, the inverse-pi engine and
// the line consumer. The master side drives lines in and takes results out.
interface inv_pi_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] line_in;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] line_out;
    logic        busy;

    modport master (
        output in_valid, line_in, out_ready,
        input  in_ready, out_valid, line_out, busy
    );

    modport slave (
        input  in_valid, line_in, out_ready,
        output in_ready, out_valid, line_out, busy
    );
endinterface

// File: rtl/inv_pi_engine.sv
// Bit-serial inverse pi permutation of a 25-bit (5x5) line.
// One output cell (i,j) is written per RUN cycle:
//   line_out[5i+j] = hold[5j + (2i+3j) mod 5]
//
// state | meaning
// IDLE  | waiting for a line, in_ready high
// RUN   | 25 cycles, one output cell per cycle, busy high
// HOLD  | result presented, out_valid high until accepted
module inv_pi_engine #(
    parameter int SIZE    = 5,
    parameter int MEMSIZE = 25,
    parameter int IDXW    = 5
) (
    input  logic           clk,
    input  logic           rst,
    inv_pi_engine_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              r_state;
    logic [MEMSIZE-1:0]  r_hold;
    logic [MEMSIZE-1:0]  r_line_out;
    logic [2:0]          r_i;
    logic [2:0]          r_j;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [IDXW-1:0]     w_sum;
    logic [IDXW-1:0]     w_col;
    logic [IDXW-1:0]     w_src;
    logic [IDXW-1:0]     w_dst;

    // Reduce a value of at most 20 modulo 5 without a divider.
    function automatic logic [IDXW-1:0] f_mod5(input logic [IDXW-1:0] v);
        logic [IDXW-1:0] r;
        if (v >= 5'd20)      r = v - 5'd20;
        else if (v >= 5'd15) r = v - 5'd15;
        else if (v >= 5'd10) r = v - 5'd10;
        else if (v >= 5'd5)  r = v - 5'd5;
        else                 r = v;
        return r;
    endfunction

    // Source and destination indices for the current cell; 2i+3j peaks at 20.
    always_comb begin
        w_sum = {1'b0, r_i, 1'b0} + {2'b00, r_j} + {1'b0, r_j, 1'b0};
        w_col = f_mod5(w_sum);
        w_src = {r_j, 2'b00} + {2'b00, r_j} + w_col;
        w_dst = {r_i, 2'b00} + {2'b00, r_i} + {2'b00, r_j};
    end

    // Control FSM and bit-serial datapath with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_line_out  <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_hold     <= bus.line_in;
                        r_line_out <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_line_out[w_dst] <= r_hold[w_src];
                    if (r_j == 3'(SIZE - 1)) begin
                        r_j <= '0;
                        if (r_i == 3'(SIZE - 1)) begin
                            r_i         <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_i <= r_i + 3'd1;
                        end
                    end else begin
                        r_j <= r_j + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Row/column counters must stay within the 5x5 grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (r_i < 3'(SIZE) && r_j < 3'(SIZE))
                else $error("inv_pi_engine counter out of range i=%0d j=%0d", r_i, r_j);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.line_out  = r_line_out;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_inv_pi_engine.sv
// Directed bench for inv_pi_engine: vector table, round trips, backpressure,
// reset mid-run and back-to-back streaming.
module tb_inv_pi_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    inv_pi_engine_if ifc ();

    inv_pi_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] din;
        logic [24:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    // Forward pi: input cell (x,y) goes to output cell (y, (2x+3y) mod 5).
    function automatic logic [24:0] fwd_pi(input logic [24:0] a);
        logic [24:0] r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[5*y + (2*x + 3*y) % 5] = a[5*x + y];
        return r;
    endfunction

    // Inverse pi: input cell (p,q) moves to output cell ((3q+p) mod 5, p).
    function automatic logic [24:0] inv_pi(input logic [24:0] a);
        logic [24:0] r = '0;
        for (int p = 0; p < 5; p++)
            for (int q = 0; q < 5; q++)
                r[5*((3*q + p) % 5) + p] = a[5*p + q];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a line in IDLE; returns one cycle after the accept edge.
    task automatic start_line(input logic [24:0] din, input string nm);
        int n = 0;
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " in_ready"}, 25'(ifc.in_ready), 25'd1);
        ifc.in_valid = 1'b1;
        ifc.line_in  = din;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.line_in  = 25'($urandom);
        chk({nm, " busy/in_ready in RUN"}, {23'd0, ifc.busy, ifc.in_ready}, 25'b10);
    endtask

    // Wait for out_valid (expected in cycle 26) and compare the result.
    task automatic wait_result(input logic [24:0] exp, input string nm);
        int n = 1;
        while (!ifc.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 25'(n), 25'd26);
        chk({nm, " line_out"}, ifc.line_out, exp);
    endtask

    task automatic accept_result(input string nm);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, {23'd0, ifc.out_valid, ifc.in_ready}, 25'b01);
    endtask

    initial begin
        logic [24:0] x;
        logic [24:0] snap;
        logic [24:0] b[3];
        int          acc[3];
        int          k, r, cyc;
        logic        stable;

        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.line_in   = '0;

        vecs[0] = '{25'd1 << 1,   25'd1 << 15,  "bit1"};
        vecs[1] = '{25'd1 << 5,   25'd1 << 6,   "bit5"};
        vecs[2] = '{25'd1 << 24,  25'd1 << 9,   "bit24"};
        vecs[3] = '{25'd1,        25'd1,        "bit0"};
        vecs[4] = '{25'd1 << 12,  25'd1 << 17,  "bit12"};
        vecs[5] = '{25'h1FFFFFF,  25'h1FFFFFF,  "ones"};
        vecs[6] = '{25'h0,        25'h0,        "zeros"};
        vecs[7] = '{fwd_pi(25'h1A5F3C7), 25'h1A5F3C7, "roundtrip"};

        repeat (2) @(negedge clk);
        chk("reset outputs", {ifc.in_ready, ifc.out_valid, ifc.busy, 22'd0}, {3'b100, 22'd0});
        chk("reset line_out", ifc.line_out, 25'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            start_line(vecs[v].din, vecs[v].name);
            wait_result(vecs[v].exp, vecs[v].name);
            accept_result(vecs[v].name);
        end

        for (int t = 0; t < 20; t++) begin
            x = 25'($urandom);
            start_line(fwd_pi(x), "random");
            wait_result(x, "random");
            accept_result("random");
        end

        // Backpressure, with a stray in_valid pulse during HOLD.
        x = 25'h0ABCDE1;
        ifc.out_ready = 1'b1;
        start_line(x, "bp");
        ifc.out_ready = 1'b0;
        wait_result(inv_pi(x), "bp");
        snap   = ifc.line_out;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            ifc.in_valid = (c == 4);
            ifc.line_in  = 25'h1555555;
            @(negedge clk);
            if (!ifc.out_valid || ifc.line_out !== snap || ifc.in_ready) stable = 1'b0;
        end
        ifc.in_valid = 1'b0;
        chk("bp hold stable", 25'(stable), 25'd1);
        chk("bp result after stray in_valid", ifc.line_out, inv_pi(x));
        accept_result("bp");

        // Reset during RUN cycle 12 discards the run.
        start_line(25'h1234567, "rst");
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst mid-run outputs", {ifc.in_ready, ifc.out_valid, ifc.busy, 22'd0}, {3'b100, 22'd0});
        chk("rst mid-run line_out", ifc.line_out, 25'd0);
        start_line(25'h0F0F0F0, "post rst");
        wait_result(inv_pi(25'h0F0F0F0), "post rst");
        accept_result("post rst");

        // Back-to-back streaming with out_ready and in_valid held high.
        b[0] = 25'h1C3A5E7; b[1] = 25'h0246813; b[2] = 25'h1FEDCBA;
        ifc.out_ready = 1'b1;
        k = 0; r = 0; cyc = 0;
        while (r < 3 && cyc < 200) begin
            ifc.in_valid = (k < 3);
            ifc.line_in  = (k < 3) ? b[k] : 25'd0;
            if (ifc.out_valid) begin
                chk("stream result", ifc.line_out, inv_pi(b[r]));
                r++;
            end
            if (ifc.in_ready && k < 3) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        chk("stream completed", 25'(r), 25'd3);
        chk("stream spacing 0-1", 25'(acc[1] - acc[0]), 25'd27);
        chk("stream spacing 1-2", 25'(acc[2] - acc[1]), 25'd27);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_pi_engine.md
Name: inv_pi_engine

Overview:
- Applies the inverse of the 5x5 pi bit permutation to one 25-bit line and returns the restored line.
- Pairs with the forward permutation datapath: its output line, fed here, yields the original line.
- Sits between the permutation core's result port and the line consumer, behind a valid/ready handshake on both sides.
- Bit-serial: visits one output cell per cycle using row/column counters and a computed source index, matching the forward datapath's cost profile.

Parameters:
- SIZE, 5, lane dimension (rows = cols = SIZE); only 5 is supported.
- MEMSIZE, 25, line width = SIZE*SIZE.
- IDXW, 5, width of linear bit index.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  line_in is valid
- in_ready  output  1  engine can accept a line (high only in IDLE)
- line_in  input  25  permuted line; bit k = cell (row k/5, col k%5)
- out_valid  output  1  line_out holds a finished result
- out_ready  input  1  consumer accepts line_out
- line_out  output  25  restored line, same bit mapping
- busy  output  1  high in RUN

Behaviour:
- Indexing: linear index k = 5*row + col, with row and col in 0..4.
- Mapping: line_out[5*i+j] = line_in[5*j + ((2*i + 3*j) mod 5)].
  - Equivalently, input cell (p,q) moves to output cell ((3q+p) mod 5, p).
- Index arithmetic is done at 5 bits with an explicit mod-5 reduction.
  - Source column = (2i+3j) mod 5, computed from 3-bit i and j; maximum intermediate value is 20.
  - No index may exceed 24.
- Reset (rst=0 at a clock edge), in any state:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - line_out=0; i=0; j=0; input holding register=0.
  - This aborts any run in progress; the partial result is discarded.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch line_in into the holding register, clear line_out, set i=j=0, go to RUN.
- RUN:
  - in_ready=0; busy=1.
  - Each cycle, write line_out[5*i+j] from the holding register via the mapping.
  - Advance j; when j wraps from 4 to 0, increment i.
  - On the cycle that writes (4,4), go to HOLD.
  - Exactly 25 RUN cycles.
- HOLD:
  - out_valid=1; line_out is stable.
  - When out_valid and out_ready are both high at an edge: go to IDLE and drop out_valid next cycle.
  - line_out keeps its value until the next accept.
- Latency: accept edge at cycle 0, RUN during cycles 1..25, out_valid high from cycle 26. Minimum 27 cycles between successive accepts.
- Boundary conditions:
  - in_valid is ignored outside IDLE; the line is not latched and no error is raised.
  - Changes to line_in after acceptance have no effect.
  - out_ready high before HOLD has no effect.
  - out_ready held high continuously: HOLD lasts exactly 1 cycle.
  - Back-to-back: in_valid high in the cycle after leaving HOLD is accepted in IDLE; no combinational path from out_ready to in_ready.
  - Counters i and j never take values 5..7; reaching one is a design error (assertion).

Test Plan:
- Single-bit routing: line_in = 1<<1 → after 25 RUN cycles, line_out = 1<<15. line_in = 1<<5 → 1<<6. line_in = 1<<24 → 1<<9. line_in = 1<<0 → 1<<0.
- Full patterns: all-ones → all-ones; all-zeros → all-zeros; out_valid first seen exactly 26 cycles after the accept edge.
- Round trip: apply the forward pi to 25'h1A5F3C7 (input (x,y) goes to output (y, (2x+3y) mod 5)), feed the result here → line_out = 25'h1A5F3C7. Repeat for 20 random lines.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → out_valid stays 1 and line_out is stable. Pulse in_valid during HOLD with another line → ignored, result unchanged.
- Reset mid-run: drive rst=0 at RUN cycle 12 → next cycle state is IDLE, in_ready=1, out_valid=0, line_out=0. A new line then processes correctly.
- Back-to-back streaming: 3 lines with out_ready=1 and in_valid=1 → accepts spaced exactly 27 cycles apart, with each result matching its mapping.
